// File: rtl/spi_cmd_decoder.sv
`default_nettype none
// ============================================================================
// spi_cmd_decoder : SPI command-frame decoder with a 4 x 8-bit register file.
// Optional XOR checksum byte via `define SPI_CMD_CHECKSUM_EN.   Rev 1.0
// ============================================================================
module spi_cmd_decoder #(
    parameter logic [7:0] CMD_WR = 8'h5A,
    parameter logic [7:0] CMD_RD = 8'hA5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cs,
    input  logic [7:0]  rxd_data,
    input  logic        rxd_flag,
    output logic [7:0]  txd_data,
    output logic [31:0] reg_out,
    output logic        led_state,
    output logic        frame_ok,
    output logic        frame_err,
    output logic [7:0]  err_cnt
);

`ifdef SPI_CMD_CHECKSUM_EN
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ADDR = 3'd1,
        DATA = 3'd2,
        CHK  = 3'd3,
        SKIP = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ADDR = 3'd1,
        DATA = 3'd2,
        SKIP = 3'd4
    } state_t;
`endif

    localparam logic [7:0] TX_ACK  = 8'h3C;
    localparam logic [7:0] TX_ERR  = 8'hEE;
    localparam logic [7:0] TX_IDLE = 8'hC3;

    state_t      state;
    logic        flag_q;
    logic        evt_q;
    logic [7:0]  byte_q;
    logic        is_wr;
    logic [1:0]  addr;
    logic [7:0]  regs [4];
    logic        byte_evt;
`ifdef SPI_CMD_CHECKSUM_EN
    logic [7:0]  wdata;
    logic [7:0]  csum;
`endif

    // Events seen while cs is high are dropped before they reach the FSM.
    assign byte_evt = rxd_flag & ~flag_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flag_q <= 1'b0;
            evt_q  <= 1'b0;
            byte_q <= 8'h00;
        end else begin
            flag_q <= rxd_flag;
            evt_q  <= byte_evt & ~cs;
            if (byte_evt)
                byte_q <= rxd_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            txd_data  <= TX_IDLE;
            frame_ok  <= 1'b0;
            frame_err <= 1'b0;
            is_wr     <= 1'b0;
            addr      <= 2'd0;
            for (int i = 0; i < 4; i++)
                regs[i] <= 8'h00;
`ifdef SPI_CMD_CHECKSUM_EN
            wdata     <= 8'h00;
            csum      <= 8'h00;
`endif
        end else begin
            frame_ok  <= 1'b0;
            frame_err <= 1'b0;
            if (cs) begin
                if (state == ADDR || state == DATA
`ifdef SPI_CMD_CHECKSUM_EN
                    || state == CHK
`endif
                   )
                    frame_err <= 1'b1;
                state    <= IDLE;
                txd_data <= TX_IDLE;
            end else if (evt_q) begin
                case (state)
                    IDLE: begin
                        if (byte_q == CMD_WR || byte_q == CMD_RD) begin
                            is_wr    <= (byte_q == CMD_WR);
                            state    <= ADDR;
                            txd_data <= TX_ACK;
`ifdef SPI_CMD_CHECKSUM_EN
                            csum     <= byte_q;
`endif
                        end else begin
                            state     <= SKIP;
                            frame_err <= 1'b1;
                            txd_data  <= TX_ERR;
                        end
                    end
                    ADDR: begin
                        if (byte_q[7:2] == 6'd0) begin
                            addr     <= byte_q[1:0];
                            state    <= DATA;
                            txd_data <= regs[byte_q[1:0]];
`ifdef SPI_CMD_CHECKSUM_EN
                            csum     <= csum ^ byte_q;
`endif
                        end else begin
                            state     <= SKIP;
                            frame_err <= 1'b1;
                            txd_data  <= TX_ERR;
                        end
                    end
`ifdef SPI_CMD_CHECKSUM_EN
                    DATA: begin
                        if (is_wr)
                            wdata <= byte_q;
                        csum  <= csum ^ byte_q;
                        state <= CHK;
                    end
                    CHK: begin
                        if (byte_q == csum) begin
                            if (is_wr) begin
                                regs[addr] <= wdata;
                                txd_data   <= wdata;
                            end else begin
                                txd_data   <= regs[addr];
                            end
                            frame_ok <= 1'b1;
                        end else begin
                            frame_err <= 1'b1;
                            txd_data  <= TX_ERR;
                        end
                        state <= SKIP;
                    end
`else
                    DATA: begin
                        if (is_wr) begin
                            regs[addr] <= byte_q;
                            txd_data   <= byte_q;
                        end else begin
                            txd_data   <= regs[addr];
                        end
                        frame_ok <= 1'b1;
                        state    <= SKIP;
                    end
`endif
                    SKIP: begin
                        state <= SKIP;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

    // Counter follows the frame_err pulse by one clk.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            err_cnt <= 8'h00;
        else if (frame_err && err_cnt != 8'hFF)
            err_cnt <= err_cnt + 8'd1;
    end

    assign reg_out   = {regs[3], regs[2], regs[1], regs[0]};
    assign led_state = regs[0][0];

endmodule
`default_nettype wire

// File: doc/spi_cmd_decoder.md
SPI_CMD_DECODER -- requirements
Module: spi_cmd_decoder

Interface
REQ-001 The block SHALL have parameter CMD_WR, default 8'h5A, meaning the write command byte.
REQ-002 The block SHALL have parameter CMD_RD, default 8'hA5, meaning the read command byte.
REQ-003 The block SHALL have port clk, input, 1 bit: single clock for all logic (30 MHz PLL clock).
REQ-004 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port cs, input, 1 bit: SPI chip select, active low, frame boundary, already synchronous to clk.
REQ-006 The block SHALL have port rxd_data, input, 8 bits: last byte received by the SPI slave.
REQ-007 The block SHALL have port rxd_flag, input, 1 bit: level flag from the SPI slave whose rising edge marks rxd_data valid.
REQ-008 The block SHALL have port txd_data, output, 8 bits: byte the SPI slave shifts out on the next transfer.
REQ-009 The block SHALL have port reg_out, output, 32 bits: register file {reg3,reg2,reg1,reg0}.
REQ-010 The block SHALL have port led_state, output, 1 bit: equal to reg0[0].
REQ-011 The block SHALL have port frame_ok, output, 1 bit: one-clk pulse on a valid completed frame.
REQ-012 The block SHALL have port frame_err, output, 1 bit: one-clk pulse on a frame error.
REQ-013 The block SHALL have port err_cnt, output, 8 bits: count of frame errors, saturating.

Function
REQ-014 The block SHALL register rxd_flag and treat a 0->1 transition as a byte event (byte_evt), one event per rising edge.
REQ-015 The state machine SHALL have states IDLE, ADDR, DATA, CHK and SKIP, and SHALL act one clk after byte_evt.
REQ-016 In IDLE, a byte event SHALL have this effect:
- byte == CMD_WR or CMD_RD: latch the command, go to ADDR, set txd_data = 8'h3C.
- any other byte: go to SKIP, pulse frame_err, set txd_data = 8'hEE.
REQ-017 In ADDR, a byte event SHALL have this effect:
- addr[7:2] == 0: latch addr[1:0], go to DATA, set txd_data = reg[addr].
- otherwise: go to SKIP, pulse frame_err, set txd_data = 8'hEE.
REQ-018 In DATA, a write frame SHALL latch the byte; a read frame SHALL ignore the byte value; the next state SHALL be CHK if SPI_CMD_CHECKSUM_EN is defined, else the commit/complete action (REQ-019) followed by SKIP.
REQ-019 Commit SHALL mean that a write updates reg[addr] and txd_data = new value, a read leaves the registers unchanged and txd_data = reg[addr], and in both cases frame_ok pulses.
REQ-020 In SKIP, bytes SHALL be ignored and txd_data SHALL hold its value until cs rises.
REQ-021 A cs high sample SHALL force IDLE in any state, discard uncommitted data, and set txd_data = 8'hC3; if cs rises in ADDR, DATA or CHK, frame_err SHALL pulse once.
REQ-022 cs high SHALL take priority over a byte event in the same clk.
REQ-023 Byte events while cs is high SHALL be ignored.
REQ-024 Latency: txd_data and reg_out SHALL be updated exactly 2 clks after the rxd_flag rising edge (1 for edge detection, 1 for the state action).
REQ-025 err_cnt SHALL increment on each frame_err and SHALL saturate at 8'hFF without wrapping.
REQ-026 frame_ok and frame_err SHALL never be asserted in the same clk.

Reset
REQ-027 While rst is high, the block SHALL be in state IDLE, reg0..reg3 = 8'h00, led_state = 0, txd_data = 8'hC3, frame_ok = 0, frame_err = 0, err_cnt = 0, and the edge-detect register = 0.
REQ-028 rst asserted mid-frame SHALL abort the frame with no register write and no frame_err pulse.

Configuration
REQ-029 When SPI_CMD_CHECKSUM_EN is defined, frames SHALL carry a fourth byte equal to the XOR of the three preceding bytes; in CHK, a match SHALL commit per REQ-019 and go to SKIP, and a mismatch SHALL pulse frame_err with txd_data = 8'hEE and go to SKIP with no write.
REQ-030 When SPI_CMD_CHECKSUM_EN is undefined, state CHK SHALL be absent and commit SHALL occur on the DATA byte.

Verification
REQ-031 A bench SHALL cover: reset, then cs low with 5A 01 7F (checksum build: 5A 01 7F 24), then cs high -> reg1 = 7F, a single frame_ok pulse, txd_data = 7F after the last byte and C3 after cs rises.
REQ-032 A bench SHALL cover: 5A 00 01 -> reg0 = 01 and led_state = 1; then A5 00 xx -> txd_data = 01 after the address byte, registers unchanged.
REQ-033 A bench SHALL cover: 33 -> frame_err pulse, txd_data = EE, err_cnt = 1; further bytes before cs rises have no effect.
REQ-034 A bench SHALL cover: 5A 07 -> frame_err pulse, no write; and 5A 02 followed by cs rising -> frame_err pulse, reg2 unchanged.
REQ-035 A bench SHALL cover: 256 bad command frames -> err_cnt holds at FF; rst pulse -> err_cnt = 00 and all regs = 00.
REQ-036 A bench SHALL cover (checksum build only): 5A 01 7F 00 -> frame_err pulse, reg1 unchanged.
